// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, tap table and FSM state type for the LFSR tap finder
package lfsr_pkg;

    localparam int NUM_TAPS = 9;
    localparam logic [3:0] NO_TAP = 4'hF;

    localparam logic [6:0] TAP_TABLE [NUM_TAPS] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEARCH  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Out-of-table indices map to an all-zero pattern so the lookup is always defined.
    function automatic logic [6:0] tap_pattern(input logic [3:0] idx);
        if (idx < 4'(NUM_TAPS)) begin
            return TAP_TABLE[idx];
        end
        return 7'h00;
    endfunction

endpackage

// File: rtl/lfsr_tap_check.sv
// rtl/lfsr_tap_check.sv - checks every stored state transition against one tap pattern
module lfsr_tap_check
    import lfsr_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic [7*LEN-1:0] states,
    input  logic [6:0]       taps,
    output logic             match
);

    logic [6:0] cur;
    logic [6:0] nxt;

    always_comb begin
        match = 1'b1;
        cur   = 7'h00;
        nxt   = 7'h00;
        for (int i = 0; i < LEN - 1; i++) begin
            cur = states[7*i +: 7];
            nxt = states[7*(i+1) +: 7];
            if (nxt != {cur[5:0], ^(taps & cur)}) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lfsr_tap_finder.sv
// rtl/lfsr_tap_finder.sv - recovers LFSR taps and seed from a ciphertext preamble
module lfsr_tap_finder
    import lfsr_pkg::*;
#(
    parameter logic [6:0] PREAMBLE_CHAR = 7'h20,
    parameter int         PREAMBLE_LEN  = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       CipherValid,
    input  logic [6:0] CipherIn,
    output logic       CipherReady,
    output logic       Busy,
    output logic       Done,
    output logic       Found,
    output logic [3:0] TapSel,
    output logic [6:0] Seed
);

    localparam logic [4:0] LAST_IDX = 5'(PREAMBLE_LEN - 1);
    localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

    state_t                    state;
    logic [4:0]                count;
    logic [3:0]                tap_idx;
    logic [7*PREAMBLE_LEN-1:0] s_vec;
    logic                      match;

    lfsr_tap_check #(
        .LEN (PREAMBLE_LEN)
    ) u_check (
        .states (s_vec),
        .taps   (tap_pattern(tap_idx)),
        .match  (match)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            count       <= 5'd0;
            tap_idx     <= 4'd0;
            s_vec       <= '0;
            CipherReady <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Found       <= 1'b0;
            TapSel      <= 4'd0;
            Seed        <= 7'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state       <= COLLECT;
                        count       <= 5'd0;
                        tap_idx     <= 4'd0;
                        CipherReady <= 1'b1;
                        Busy        <= 1'b1;
                    end
                end
                COLLECT: begin
                    // Stored value is the keystream state: ciphertext with the known plaintext removed.
                    if (CipherValid) begin
                        s_vec[count*7 +: 7] <= CipherIn ^ PREAMBLE_CHAR;
                        count               <= count + 5'd1;
                        if (count == LAST_IDX) begin
                            state       <= SEARCH;
                            CipherReady <= 1'b0;
                        end
                    end
                end
                SEARCH: begin
                    if (match || tap_idx == LAST_TAP) begin
                        state  <= DONE;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        Found  <= match;
                        TapSel <= match ? tap_idx : NO_TAP;
                        Seed   <= s_vec[6:0];
                    end else begin
                        tap_idx <= tap_idx + 4'd1;
                    end
                end
                DONE: begin
                    if (Start) begin
                        state       <= COLLECT;
                        count       <= 5'd0;
                        tap_idx     <= 4'd0;
                        CipherReady <= 1'b1;
                        Busy        <= 1'b1;
                        Done        <= 1'b0;
                        Found       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_tap_finder.sv
// tb/tb_lfsr_tap_finder.sv - directed self-checking bench for lfsr_tap_finder
module tb_lfsr_tap_finder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       CipherValid = 1'b0;
    logic [6:0] CipherIn = 7'h00;
    logic       CipherReady;
    logic       Busy;
    logic       Done;
    logic       Found;
    logic [3:0] TapSel;
    logic [6:0] Seed;

    int n_cmp = 0;
    int n_bad = 0;
    int accepted = 0;
    logic [6:0] stream [8];
    logic [6:0] taps_ref [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    lfsr_tap_finder #(
        .PREAMBLE_CHAR (7'h20),
        .PREAMBLE_LEN  (8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .CipherValid (CipherValid),
        .CipherIn    (CipherIn),
        .CipherReady (CipherReady),
        .Busy        (Busy),
        .Done        (Done),
        .Found       (Found),
        .TapSel      (TapSel),
        .Seed        (Seed)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (CipherValid && CipherReady) accepted++;
    end

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(t & s)};
    endfunction

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic send_all(input int gap_max);
        for (int k = 0; k < 8; k++) begin
            int b;
            repeat ($urandom_range(0, gap_max)) @(negedge Clk);
            CipherValid = 1'b1;
            CipherIn    = stream[k];
            b = 0;
            while (!CipherReady && b < 50) begin
                @(negedge Clk);
                b++;
            end
            n_cmp++;
            if (b >= 50) begin
                n_bad++;
                $display("FAIL send_ready_timeout: char %0d never accepted (required CipherReady=1)", k);
            end
            @(negedge Clk);
            CipherValid = 1'b0;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 30) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic check_result(input string name, input int lat, input int lat_exp,
                                input logic f_exp, input logic [3:0] t_exp, input logic [6:0] s_exp);
        n_cmp++; if (Done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", name, Done); end
        n_cmp++; if (lat != lat_exp) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, lat_exp); end
        n_cmp++; if (Found !== f_exp) begin n_bad++; $display("FAIL %s_found: got %b want %b", name, Found, f_exp); end
        n_cmp++; if (TapSel !== t_exp) begin n_bad++; $display("FAIL %s_tapsel: got %h want %h", name, TapSel, t_exp); end
        n_cmp++; if (Seed !== s_exp) begin n_bad++; $display("FAIL %s_seed: got %h want %h", name, Seed, s_exp); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", name, Busy); end
    endtask

    task automatic check_reset_values(input string name);
        n_cmp++;
        if ({CipherReady, Busy, Done, Found, TapSel, Seed} !== 15'd0) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b found=%b tap=%h seed=%h want all 0",
                     name, CipherReady, Busy, Done, Found, TapSel, Seed);
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_values("reset_values");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_basic();
        int lat;
        stream = '{7'h21, 7'h22, 7'h24, 7'h28, 7'h30, 7'h00, 7'h61, 7'h23};
        accepted = 0;
        pulse_start();
        n_cmp++; if (CipherReady !== 1'b1 || Busy !== 1'b1) begin n_bad++; $display("FAIL collect_flags: got rdy=%b busy=%b want 1 1", CipherReady, Busy); end
        send_all(0);
        n_cmp++; if (CipherReady !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) begin n_bad++; $display("FAIL search_flags: got rdy=%b busy=%b done=%b want 0 1 0", CipherReady, Busy, Done); end
        wait_done(lat);
        check_result("basic", lat, 1, 1'b1, 4'd0, 7'h01);
        n_cmp++; if (accepted != 8) begin n_bad++; $display("FAIL basic_accepted: got %0d want 8", accepted); end
    endtask

    task automatic test_back_to_back_zero();
        int lat;
        for (int k = 0; k < 8; k++) stream[k] = 7'h20;
        pulse_start();
        n_cmp++; if (Done !== 1'b0 || CipherReady !== 1'b1) begin n_bad++; $display("FAIL restart_from_done: got done=%b rdy=%b want 0 1", Done, CipherReady); end
        send_all(0);
        wait_done(lat);
        check_result("zero_state", lat, 1, 1'b1, 4'd0, 7'h00);
    endtask

    task automatic test_no_match();
        int lat;
        for (int k = 0; k < 8; k++) stream[k] = 7'h00;
        pulse_start();
        send_all(0);
        wait_done(lat);
        check_result("no_match", lat, 9, 1'b0, 4'hF, 7'h20);
        repeat (3) @(negedge Clk);
        n_cmp++; if (Done !== 1'b1 || TapSel !== 4'hF || Seed !== 7'h20) begin n_bad++; $display("FAIL done_hold: got done=%b tap=%h seed=%h want 1 f 20", Done, TapSel, Seed); end
    endtask

    task automatic test_gaps_and_start();
        stream = '{7'h21, 7'h22, 7'h24, 7'h28, 7'h30, 7'h00, 7'h61, 7'h23};
        pulse_start();
        accepted = 0;
        send_all(3);
        Start       = 1'b1;
        CipherValid = 1'b1;
        CipherIn    = 7'h7F;
        @(negedge Clk);
        Start = 1'b0;
        n_cmp++; if (Done !== 1'b1 || CipherReady !== 1'b0) begin n_bad++; $display("FAIL gaps_done: got done=%b rdy=%b want 1 0", Done, CipherReady); end
        @(negedge Clk);
        CipherValid = 1'b0;
        check_result("gaps", 1, 1, 1'b1, 4'd0, 7'h01);
        n_cmp++; if (accepted != 8) begin n_bad++; $display("FAIL gaps_accepted: got %0d want 8", accepted); end
    endtask

    task automatic test_reset_mid_search();
        int lat;
        int exp_idx;
        logic [6:0] s [8];
        for (int k = 0; k < 8; k++) stream[k] = 7'h00;
        pulse_start();
        send_all(0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_reset_values("reset_mid_search");
        @(negedge Clk);
        Reset = 1'b0;
        s[0] = 7'h55;
        for (int k = 1; k < 8; k++) s[k] = step(s[k-1], 7'h7B);
        for (int k = 0; k < 8; k++) stream[k] = s[k] ^ 7'h20;
        exp_idx = -1;
        for (int t = 8; t >= 0; t--) begin
            bit ok = 1'b1;
            for (int k = 0; k < 7; k++) if (step(s[k], taps_ref[t]) != s[k+1]) ok = 1'b0;
            if (ok) exp_idx = t;
        end
        pulse_start();
        send_all(1);
        wait_done(lat);
        check_result("taps_7b", lat, exp_idx + 1, 1'b1, 4'(exp_idx), 7'h55);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back_zero();
        test_no_match();
        test_gaps_and_start();
        test_reset_mid_search();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
